fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle decode/execute datapath. It owns the program counter and issues word requests to a synchronous instruction memory with one cycle of read latency. It buffers returned instructions with their PCs in a small FIFO and presents them through a valid/ready handshake. A taken branch or jump from the execute side redirects fetch and flushes all wrong-path instructions.

---
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 107 ++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing single-latency imem reads into a small {instr,pc} FIFO
// with valid/ready output and redirect-driven flush.
module fetch_unit #(
    parameter int              DATA_WIDTH = 32,
    parameter int              ADDR_WIDTH = 32,
    parameter int              DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_ready_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    input  logic                  instr_ready_i
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int PEW = CW + 1;

    logic [DATA_WIDTH-1:0] mem_instr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc_q    [DEPTH];
    logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, inflight_pc_q;
    logic                  inflight_q, discard_q, discard_d;
    logic                  pop, push, accept;
    logic [PEW-1:0]        pend;

    assign instr_valid_o = cnt_q != '0;
    assign instr_o       = instr_valid_o ? mem_instr_q[rd_q] : '0;
    assign instr_pc_o    = instr_valid_o ? mem_pc_q[rd_q] : '0;
    assign imem_addr_o   = fetch_pc_q;
    assign pop           = instr_valid_o && instr_ready_i && !redirect_i;
    // Buffered plus in-flight words after this cycle's pop must leave room for one more.
    assign pend          = PEW'(cnt_q) + PEW'(inflight_q) - PEW'(pop);
    assign imem_req_o    = rst && !redirect_i && (pend < PEW'(DEPTH));
    assign accept        = imem_req_o && imem_ready_i;
    assign push          = inflight_q && !discard_q && !redirect_i;

    always_comb begin
        fetch_pc_d = redirect_i ? {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00}
                   : accept     ? fetch_pc_q + ADDR_WIDTH'(4) : fetch_pc_q;
        discard_d  = redirect_i && accept;
        wr_d       = redirect_i ? '0 : push ? wr_q + PW'(1) : wr_q;
        rd_d       = redirect_i ? '0 : pop ? rd_q + PW'(1) : rd_q;
        cnt_d      = redirect_i ? '0 : cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            discard_q     <= 1'b0;
            wr_q          <= '0;
            rd_q          <= '0;
            cnt_q         <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= accept;
            inflight_pc_q <= fetch_pc_q;
            discard_q     <= discard_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            cnt_q         <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr_q[wr_q] <= imem_rdata_i;
            mem_pc_q[wr_q]    <= inflight_pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random stimulus against a queue-of-accepted-requests reference model.
module tb_fetch_unit;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0;
    localparam logic [31:0] K     = 32'hDEAD_0000;

    logic        clk = 0, rst = 0;
    logic        redirect_i = 0, imem_ready_i = 0, instr_ready_i = 0;
    logic [31:0] redirect_pc_i = 0, imem_rdata_i = 0;
    logic        imem_req_o, instr_valid_o;
    logic [31:0] imem_addr_o, instr_o, instr_pc_o;

    fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
        .imem_rdata_i(imem_rdata_i), .instr_valid_o(instr_valid_o), .instr_o(instr_o),
        .instr_pc_o(instr_pc_o), .instr_ready_i(instr_ready_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) imem_rdata_i <= imem_addr_o ^ K;

    typedef struct {logic [31:0] pc; int c;} req_t;
    req_t        q[$];
    logic [31:0] fpc = RPC;
    int          cyc = 0, n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int p_ir, input int p_mr, input int p_rd);
        bit ev, pop, ereq, acc;
        logic [31:0] tgt;
        req_t r;
        @(negedge clk);
        instr_ready_i = $urandom_range(99) < p_ir;
        imem_ready_i  = $urandom_range(99) < p_mr;
        redirect_i    = $urandom_range(99) < p_rd;
        tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'hFFF);
        redirect_pc_i = tgt;
        #1;
        ev = q.size() > 0 && q[0].c <= cyc - 2;
        check("valid", instr_valid_o, ev);
        check("instr", instr_o, ev ? q[0].pc ^ K : 32'h0);
        check("pc", instr_pc_o, ev ? q[0].pc : 32'h0);
        pop  = ev && instr_ready_i && !redirect_i;
        ereq = !redirect_i && (q.size() - int'(pop)) < DEPTH;
        check("req", imem_req_o, ereq);
        check("addr", imem_addr_o, fpc);
        acc = ereq && imem_ready_i;
        @(posedge clk);
        if (redirect_i) begin
            q.delete();
            fpc = tgt & ~32'h3;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                r.pc = fpc;
                r.c  = cyc;
                q.push_back(r);
                fpc += 4;
            end
        end
        cyc++;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1 rst = 0;
        #1;
        check("rst_valid", instr_valid_o, 1'b0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_pc", instr_pc_o, 32'h0);
        check("rst_req", imem_req_o, 1'b0);
        check("rst_addr", imem_addr_o, RPC);
        @(posedge clk);
        #1 rst = 1;
        q.delete();
        fpc = RPC;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1;
        repeat (30) step(100, 100, 0);
        repeat (10) step(0, 100, 0);
        repeat (20) step(100, 100, 0);
        repeat (400) step(70, 70, 5);
        repeat (400) step(50, 50, 10);
        repeat (200) step(100, 100, 30);
        repeat (20) step(100, 100, 0);
        repeat (3) step(0, 100, 0);
        mid_reset();
        repeat (30) step(100, 100, 0);
        repeat (400) step(80, 60, 5);
        repeat (5) step(40, 100, 0);
        mid_reset();
        repeat (200) step(60, 40, 8);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
